// File: rtl/ring_seq_monitor_pkg.sv
// Shared types and helpers for the ring counter sequence monitor.
package ring_seq_monitor_pkg;

    // Width of the ring counter this monitor is normally paired with.
    localparam int RING_W = 4;

    // Width of the consecutive-mismatch run counter; holds limits up to 15.
    localparam int RUN_W = 4;

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        TRACK  = 2'd1,
        CLEAR  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    // Next value of the ring counter after one edge: right shift with the
    // inverted MSB fed back, or unchanged when the counter is holding.
    function automatic logic [RING_W-1:0] ring_next(
        input logic [RING_W-1:0] prev,
        input logic              hold
    );
        if (hold) begin
            return prev;
        end
        return {~prev[RING_W-1], prev[RING_W-1:1]};
    endfunction

endpackage

// File: rtl/ring_next_pred.sv
// Combinational predictor of the next ring counter value for any width >= 2.
module ring_next_pred #(
    parameter int W = 4
) (
    input  logic [W-1:0] prev,
    input  logic         hold,
    output logic [W-1:0] pred
);

    assign pred = hold ? prev : {~prev[W-1], prev[W-1:1]};

endmodule

// File: rtl/ring_seq_monitor.sv
// Checks a 4-bit inverted-feedback ring counter step by step, counts good
// shift steps and asks the counter to clear after repeated mismatches.
module ring_seq_monitor
    import ring_seq_monitor_pkg::*;
#(
    parameter int W         = RING_W,
    parameter int ERR_LIMIT = 2,
    parameter int CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             S1,
    input  logic [W-1:0]     Q,
    output logic             CLR_REQN,
    output logic             ERR,
    output logic             ERR_STICKY,
    output logic             LOCKED,
    output logic [CNT_W-1:0] STEP_CNT
);

    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(ERR_LIMIT);

    state_t             state_q, state_d;
    logic [W-1:0]       prev_q, prev_d;
    logic               hold_q, hold_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [RUN_W-1:0]   run_inc;
    logic [CNT_W-1:0]   step_q, step_d;
    logic               err_q, err_d;
    logic               sticky_q, sticky_d;
    logic               clr_reqn_q, clr_reqn_d;
    logic               resync_q, resync_d;
    logic [W-1:0]       pred;

    // The prediction always comes from the sample and mode of the same edge,
    // so an S1 toggle is judged against the mode in force during the step.
    ring_next_pred #(.W(W)) u_pred (
        .prev (prev_q),
        .hold (hold_q),
        .pred (pred)
    );

    // Next-state logic: sampling, compare, mismatch run and clear handshake.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        hold_d     = hold_q;
        run_d      = run_q;
        step_d     = step_q;
        sticky_d   = sticky_q;
        resync_d   = resync_q;
        err_d      = 1'b0;
        clr_reqn_d = 1'b1;
        run_inc    = (run_q >= RUN_LIMIT) ? RUN_LIMIT : run_q + RUN_W'(1);

        if (!EN) begin
            // Paused: everything holds, but the held sample goes stale.
            resync_d = 1'b1;
        end else begin
            prev_d   = Q;
            hold_d   = S1;
            resync_d = 1'b0;
            unique case (state_q)
                ACQ: begin
                    state_d = TRACK;
                    run_d   = '0;
                end
                TRACK: begin
                    if (resync_q) begin
                        // First edge after a pause only re-acquires.
                        run_d = '0;
                    end else if (Q == pred) begin
                        run_d = '0;
                        if (!hold_q) begin
                            step_d = step_q + CNT_W'(1);
                        end
                    end else begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                        run_d    = run_inc;
                        if (run_inc == RUN_LIMIT) begin
                            state_d    = CLEAR;
                            clr_reqn_d = 1'b0;
                        end
                    end
                end
                CLEAR: begin
                    // A low CLR_REQN already went out unless a pause cancelled it.
                    if (!clr_reqn_q) begin
                        run_d   = '0;
                        state_d = SETTLE;
                    end else begin
                        clr_reqn_d = 1'b0;
                    end
                end
                SETTLE: begin
                    if (resync_q) begin
                        state_d = TRACK;
                        run_d   = '0;
                    end else if (Q == '0) begin
                        state_d = TRACK;
                        prev_d  = '0;
                    end else begin
                        err_d      = 1'b1;
                        sticky_d   = 1'b1;
                        state_d    = CLEAR;
                        clr_reqn_d = 1'b0;
                    end
                end
                default: state_d = ACQ;
            endcase
        end
    end

    // State and registered outputs; reset wins over every other input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ACQ;
            prev_q     <= '0;
            hold_q     <= 1'b0;
            run_q      <= '0;
            step_q     <= '0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
            clr_reqn_q <= 1'b1;
            resync_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            hold_q     <= hold_d;
            run_q      <= run_d;
            step_q     <= step_d;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
            clr_reqn_q <= clr_reqn_d;
            resync_q   <= resync_d;
        end
    end

    assign CLR_REQN   = clr_reqn_q;
    assign ERR        = err_q;
    assign ERR_STICKY = sticky_q;
    assign STEP_CNT   = step_q;
    assign LOCKED     = (state_q == TRACK) && (run_q == '0) && !resync_q;

endmodule
